// File: rtl/exe_muldiv_if.sv
// Request/response bundle between the Execute stage and the iterative RV32M multiply/divide unit.
// The Execute stage drives the request side; the unit drives stall/busy/done/result.
interface exe_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, kill,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, op, a, b, kill,
    output stall, busy, done, result
  );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// fixed 33-cycle latency from accept to done, abortable by kill.
module exe_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  exe_muldiv_if.slave io
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic                neg_q, neg_d;
  logic                bzero_q, bzero_d;
  logic                ovf_q, ovf_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                is_div;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_part;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   step_prod;
  logic [XLEN-1:0]     step_rem;
  logic [2*XLEN-1:0]   prod_signed;
  logic [XLEN-1:0]     quo_signed, rem_signed;
  logic [XLEN-1:0]     fin_result;

  // MULHSU treats rs1 as signed but rs2 as unsigned
  assign a_signed = (io.op == 3'b001) || (io.op == 3'b010) || (io.op == 3'b100) || (io.op == 3'b110);
  assign b_signed = (io.op == 3'b001) || (io.op == 3'b100) || (io.op == 3'b110);
  assign a_neg    = a_signed && io.a[XLEN-1];
  assign b_neg    = b_signed && io.b[XLEN-1];
  assign a_mag    = a_neg ? -io.a : io.a;
  assign b_mag    = b_neg ? -io.b : io.b;

  // Multiply: prod = {acc, multiplier}; divide: prod low half shifts dividend out, quotient in
  assign is_div   = op_q[2];
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + ({1'b0, opnd_q} & {(XLEN+1){prod_q[0]}});
  assign div_part = {rem_q, prod_q[XLEN-1]};
  assign div_ge   = div_part >= {1'b0, opnd_q};
  assign div_diff = div_part[XLEN-1:0] - opnd_q;

  assign step_prod = is_div ? {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], div_ge}
                            : {mul_sum, prod_q[XLEN-1:1]};
  assign step_rem  = is_div ? (div_ge ? div_diff : div_part[XLEN-1:0]) : rem_q;

  assign prod_signed = neg_q ? -step_prod : step_prod;
  assign quo_signed  = neg_q ? -step_prod[XLEN-1:0] : step_prod[XLEN-1:0];
  assign rem_signed  = neg_q ? -step_rem : step_rem;

  always_comb begin
    fin_result = quo_signed;
    if (!op_q[2]) begin
      fin_result = (op_q[1:0] == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    end else if (bzero_q) begin
      fin_result = op_q[1] ? a_q : '1;
    end else if (ovf_q) begin
      fin_result = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else if (op_q[1]) begin
      fin_result = rem_signed;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    if (io.kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.start) begin
            state_d = S_RUN;
            cnt_d   = '0;
            op_d    = io.op;
            a_d     = io.a;
            rem_d   = '0;
            bzero_d = (io.b == '0);
            ovf_d   = io.op[2] && b_signed && (io.a == {1'b1, {(XLEN-1){1'b0}}}) && (&io.b);
            if (io.op[2]) begin
              prod_d = {{XLEN{1'b0}}, a_mag};
              opnd_d = b_mag;
              neg_d  = io.op[1] ? a_neg : (a_neg ^ b_neg);
            end else begin
              prod_d = {{XLEN{1'b0}}, b_mag};
              opnd_d = a_mag;
              neg_d  = a_neg ^ b_neg;
            end
          end
        end
        S_RUN: begin
          prod_d = step_prod;
          rem_d  = step_rem;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = fin_result;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign io.busy   = (state_q != S_IDLE);
  assign io.done   = (state_q == S_DONE);
  assign io.stall  = ((state_q == S_IDLE) && io.start && !io.kill) || (state_q == S_RUN);
  assign io.result = result_q;

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage, alongside the ALU.
- Consumes the decoded M-extension operation (funct3 of OPC_ARI_RTYPE with funct7=0000001) plus both operands.
- Produces a 32-bit result after a fixed multi-cycle latency.
- Stalls the front of the pipeline while iterating and is flushed by the hazard/branch logic via kill.

Parameters:
XLEN, 32, operand/result width; only 32 supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a  input  32  rs1 value.
b  input  32  rs2 value.
kill  input  1  flush; aborts any in-flight or starting operation.
stall  output  1  hold upstream stages and the Execute pipeline register.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse; result valid this cycle.
result  output  32  operation result; held until the next start is accepted.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, counter=0, done=0, busy=0, result=0, all internal registers cleared. Reset overrides start and kill.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1 and kill=0.
  - RUN -> DONE after 32 iterations.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on kill=1.
- Latency: start sampled at edge E0; iterations at E1..E32; done=1 and result valid in the cycle following E32; return to IDLE at E33.
  - Fixed 33-cycle latency for all eight ops, including divide-by-zero and overflow cases.
- stall = (state==IDLE && start && !kill) || state==RUN. stall is 0 in DONE so the pipeline captures result that cycle.
- On accept, operands are latched; a/b changes during RUN are ignored.
  - Signed ops (MULH, DIV, REM: both operands; MULHSU: a only) latch magnitudes and record the result sign.
  - Result sign for MUL*: sign(a) XOR sign(b) over signed operands. DIV: sign(a) XOR sign(b). REM: sign(a).
- Multiply: shift-add, one multiplier bit per iteration, into a 64-bit product register.
  - Final 64-bit product is negated if its sign flag is set.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring, one quotient bit per iteration, with a 33-bit partial remainder.
  - Quotient is negated if its sign flag is set; remainder is negated if sign(a) for REM.
- Special cases are resolved in DONE, overriding the algorithm:
  - b==0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = a (original value).
  - DIV with a=0x80000000, b=0xFFFFFFFF: result 0x80000000. REM in the same case: result 0.
- done is asserted exactly one cycle per accepted, unkilled operation, and never during reset or after kill.
- start asserted while busy is ignored; no queuing. Upstream holds start until it observes done.
- kill and start in the same IDLE cycle: kill wins, nothing is accepted, stall=0.
- kill in DONE: done still shows 1 that cycle (combinational on state); state returns to IDLE. Hazard logic discards it.
- result register updates only on entry to DONE.
- Reset asserted mid-RUN: IDLE at that edge, no done pulse, result=0.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), start 1 cycle -> stall high 33 cycles (incl. start cycle), done pulses once 33 cycles after E0, result=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=123, b=0 -> 0xFFFFFFFF. REM a=5, b=0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. All with done at the same fixed latency.
- Start DIV, assert kill at iteration 10 -> IDLE next edge, stall=0, no done pulse. New MUL 3*4 started immediately after -> result 12. Toggling a/b and start during RUN -> no effect on result.
- Start, then rst_n=0 at iteration 20 -> busy=0, result=0, no done. Separately, start+kill in the same IDLE cycle -> state stays IDLE, stall=0.
